regfile_sb: RTL and testbench

- Parametrised successor to the single-write, dual-read RISC-V register file.
- Adds three things:
  - a configurable number of read ports;
  - optional write-to-read bypass;
  - a per-register pending-write scoreboard with a live busy count, so the decode stage can detect RAW hazards without a separate hazard unit.
- Sits between decode (read/issue side) and writeback (write side) of the pipelined core.

---
 rtl/regfile_pkg.sv | 17 +
 rtl/regfile_sb_if.sv | 33 +++
 rtl/regfile_scoreboard.sv | 61 ++++++
 rtl/regfile_sb.sv | 59 +++++
 tb/tb_regfile_sb.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the scoreboarded register file.
package regfile_pkg;

    localparam int XLEN_DEFAULT = 32;
    localparam int ZERO_REG     = 0;

    // Low bit of element idx inside a flattened bus of width-wide elements.
    function automatic int slice_lo(input int idx, input int width);
        return idx * width;
    endfunction

    // Width needed to hold a count of 0..nregs.
    function automatic int cnt_width(input int nregs);
        return $clog2(nregs + 1);
    endfunction

endpackage

// File: rtl/regfile_sb_if.sv
// Decode/writeback bus of the register file: read ports, writeback, issue and busy status.
interface regfile_sb_if
    import regfile_pkg::*;
#(
    parameter int XLEN  = XLEN_DEFAULT,
    parameter int NREGS = 32,
    parameter int NREAD = 2
);
    localparam int AW = $clog2(NREGS);
    localparam int CW = cnt_width(NREGS);

    logic [NREAD*AW-1:0]   rd_addr;
    logic [NREAD*XLEN-1:0] rd_data;
    logic [NREAD-1:0]      rd_busy;
    logic                  wr_en;
    logic [AW-1:0]         wr_addr;
    logic [XLEN-1:0]       wr_data;
    logic                  iss_en;
    logic [AW-1:0]         iss_addr;
    logic [CW-1:0]         busy_cnt;
    logic                  any_busy;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr,
        input  rd_data, rd_busy, busy_cnt, any_busy
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr,
        output rd_data, rd_busy, busy_cnt, any_busy
    );

endinterface

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one busy bit per register plus a running count of busy registers.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NREGS = 32,
    parameter int AW    = $clog2(NREGS),
    parameter int CW    = cnt_width(NREGS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_iss_en,
    input  logic [AW-1:0]    i_iss_addr,
    input  logic             i_wr_en,
    input  logic [AW-1:0]    i_wr_addr,
    output logic [NREGS-1:0] o_busy,
    output logic [CW-1:0]    o_busy_cnt,
    output logic             o_any_busy
);

    logic [NREGS-1:0] r_busy;
    logic [NREGS-1:0] w_busy_next;
    logic [CW-1:0]    r_busy_cnt;
    logic [CW-1:0]    w_busy_cnt_next;
    logic             w_set;
    logic             w_clr;
    logic             w_inc;
    logic             w_dec;

    always_comb begin
        w_set       = i_iss_en && (i_iss_addr != AW'(ZERO_REG));
        w_clr       = i_wr_en && (i_wr_addr != AW'(ZERO_REG));
        w_busy_next = r_busy;
        if (w_clr) w_busy_next[i_wr_addr] = 1'b0;
        // Applied after the clear so an issue and writeback to one register leaves it busy.
        if (w_set) w_busy_next[i_iss_addr] = 1'b1;
        w_inc = w_set && !r_busy[i_iss_addr];
        w_dec = w_clr && r_busy[i_wr_addr] && !(w_set && (i_iss_addr == i_wr_addr));
        w_busy_cnt_next = r_busy_cnt + CW'(w_inc) - CW'(w_dec);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy     <= '0;
            r_busy_cnt <= '0;
        end else begin
            r_busy     <= w_busy_next;
            r_busy_cnt <= w_busy_cnt_next;
        end
    end

    assign o_busy     = r_busy;
    assign o_busy_cnt = r_busy_cnt;
    assign o_any_busy = (r_busy_cnt != '0);

    a_cnt_is_popcount: assert property (@(posedge clk) disable iff (!rst_n)
        r_busy_cnt == CW'($countones(r_busy)));

    a_zero_never_busy: assert property (@(posedge clk) disable iff (!rst_n)
        !r_busy[ZERO_REG]);

endmodule

// File: rtl/regfile_sb.sv
// Multi-port register file with optional write-to-read bypass and a RAW-hazard scoreboard.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int XLEN   = XLEN_DEFAULT,
    parameter int NREGS  = 32,
    parameter int NREAD  = 2,
    parameter int BYPASS = 1,
    parameter int AW     = $clog2(NREGS),
    parameter int CW     = cnt_width(NREGS)
) (
    input  logic         clk,
    input  logic         rst_n,
    regfile_sb_if.slave  bus
);

    logic [XLEN-1:0]  r_mem [NREGS];
    logic [NREGS-1:0] w_busy;
    logic             w_wr_valid;

    assign w_wr_valid = bus.wr_en && (bus.wr_addr != AW'(ZERO_REG));

    // Register 0 is never written, so its reset value of zero is permanent.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) r_mem[i] <= '0;
        end else if (w_wr_valid) begin
            r_mem[bus.wr_addr] <= bus.wr_data;
        end
    end

    regfile_scoreboard #(
        .NREGS (NREGS),
        .AW    (AW),
        .CW    (CW)
    ) u_scoreboard (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_iss_en   (bus.iss_en),
        .i_iss_addr (bus.iss_addr),
        .i_wr_en    (bus.wr_en),
        .i_wr_addr  (bus.wr_addr),
        .o_busy     (w_busy),
        .o_busy_cnt (bus.busy_cnt),
        .o_any_busy (bus.any_busy)
    );

    for (genvar gi = 0; gi < NREAD; gi++) begin : g_rd
        logic [AW-1:0] w_addr;
        logic          w_hit;

        assign w_addr = bus.rd_addr[slice_lo(gi, AW) +: AW];
        // A forwarded write also hides the busy bit: the value being waited for is on the bus now.
        assign w_hit  = (BYPASS != 0) && rst_n && w_wr_valid && (w_addr == bus.wr_addr);
        assign bus.rd_data[slice_lo(gi, XLEN) +: XLEN] = w_hit ? bus.wr_data : r_mem[w_addr];
        assign bus.rd_busy[gi] = w_hit ? 1'b0 : w_busy[w_addr];
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: directed checks on a 32x32 bypassing instance, random traffic on a 16x64 non-bypassing one.
module tb_regfile_sb;

    logic clk;
    logic rst_n;

    regfile_sb_if #(.XLEN(32), .NREGS(32), .NREAD(2)) bus_a ();
    regfile_sb_if #(.XLEN(64), .NREGS(16), .NREAD(4)) bus_b ();

    regfile_sb #(.XLEN(32), .NREGS(32), .NREAD(2), .BYPASS(1)) dut_a (
        .clk (clk), .rst_n (rst_n), .bus (bus_a)
    );
    regfile_sb #(.XLEN(64), .NREGS(16), .NREAD(4), .BYPASS(0)) dut_b (
        .clk (clk), .rst_n (rst_n), .bus (bus_b)
    );

    typedef struct {
        string       tag;
        int          unit;
        int          kind;
        int          port;
        logic [63:0] exp;
    } sb_entry_t;

    sb_entry_t   sb_q [$];
    int          n_checks = 0;
    int          n_errors = 0;
    logic [63:0] m_mem  [2][32];
    logic        m_busy [2][32];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: unit 0 mirrors dut_a, unit 1 mirrors dut_b.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int u = 0; u < 2; u++)
                for (int r = 0; r < 32; r++) begin
                    m_mem[u][r]  <= '0;
                    m_busy[u][r] <= 1'b0;
                end
        end else begin
            if (bus_a.wr_en && bus_a.wr_addr != 0) begin
                m_mem[0][bus_a.wr_addr]  <= 64'(bus_a.wr_data);
                m_busy[0][bus_a.wr_addr] <= 1'b0;
            end
            if (bus_a.iss_en && bus_a.iss_addr != 0) m_busy[0][bus_a.iss_addr] <= 1'b1;
            if (bus_b.wr_en && bus_b.wr_addr != 0) begin
                m_mem[1][bus_b.wr_addr]  <= bus_b.wr_data;
                m_busy[1][bus_b.wr_addr] <= 1'b0;
            end
            if (bus_b.iss_en && bus_b.iss_addr != 0) m_busy[1][bus_b.iss_addr] <= 1'b1;
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h expected=%0h @%0t", tag, act, exp, $time);
        end
    endtask

    function automatic int model_popcount(input int u);
        int n = 0;
        for (int r = 0; r < 32; r++) n += int'(m_busy[u][r]);
        return n;
    endfunction

    function automatic int rd_addr_of(input int u, input int p);
        if (u == 0) return int'(bus_a.rd_addr[p*5 +: 5]);
        return int'(bus_b.rd_addr[p*4 +: 4]);
    endfunction

    function automatic logic [63:0] get_act(input int u, input int k, input int p);
        if (u == 0) begin
            case (k)
                0:       return 64'(bus_a.rd_data[p*32 +: 32]);
                1:       return 64'(bus_a.rd_busy[p]);
                2:       return 64'(bus_a.busy_cnt);
                default: return 64'(bus_a.any_busy);
            endcase
        end
        case (k)
            0:       return bus_b.rd_data[p*64 +: 64];
            1:       return 64'(bus_b.rd_busy[p]);
            2:       return 64'(bus_b.busy_cnt);
            default: return 64'(bus_b.any_busy);
        endcase
    endfunction

    // Push this cycle's expected outputs from the model, let them settle, then pop and compare.
    task automatic sample(input int u);
        int          np;
        bit          byp;
        bit          we;
        int          wa;
        logic [63:0] wd;
        int          a;
        bit          hit;
        int          cnt;
        sb_entry_t   e;
        if (u == 0) begin
            np = 2; byp = 1; we = bus_a.wr_en; wa = int'(bus_a.wr_addr); wd = 64'(bus_a.wr_data);
        end else begin
            np = 4; byp = 0; we = bus_b.wr_en; wa = int'(bus_b.wr_addr); wd = bus_b.wr_data;
        end
        for (int p = 0; p < np; p++) begin
            a   = rd_addr_of(u, p);
            hit = byp && rst_n && we && (wa != 0) && (wa == a);
            sb_q.push_back('{$sformatf("u%0d_rd_data%0d_r%0d", u, p, a), u, 0, p,
                             hit ? wd : m_mem[u][a]});
            sb_q.push_back('{$sformatf("u%0d_rd_busy%0d_r%0d", u, p, a), u, 1, p,
                             hit ? 64'd0 : 64'(m_busy[u][a])});
        end
        cnt = model_popcount(u);
        sb_q.push_back('{$sformatf("u%0d_busy_cnt", u), u, 2, 0, 64'(cnt)});
        sb_q.push_back('{$sformatf("u%0d_any_busy", u), u, 3, 0, 64'(cnt != 0)});
        #2;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check_eq(e.tag, get_act(e.unit, e.kind, e.port), e.exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus_a.wr_en = 1'b0; bus_a.wr_addr = '0; bus_a.wr_data = '0;
        bus_a.iss_en = 1'b0; bus_a.iss_addr = '0; bus_a.rd_addr = '0;
        bus_b.wr_en = 1'b0; bus_b.wr_addr = '0; bus_b.wr_data = '0;
        bus_b.iss_en = 1'b0; bus_b.iss_addr = '0; bus_b.rd_addr = '0;
    endtask

    task automatic set_rd_a(input int a0, input int a1);
        bus_a.rd_addr = {5'(a1), 5'(a0)};
    endtask

    task automatic drive_a(input bit we, input int wa, input logic [31:0] wd, input bit ie, input int ia);
        bus_a.wr_en = we; bus_a.wr_addr = 5'(wa); bus_a.wr_data = wd;
        bus_a.iss_en = ie; bus_a.iss_addr = 5'(ia);
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        repeat (2) tick();

        // Reset state on every address of both units.
        for (int i = 0; i < 32; i++) begin
            set_rd_a(i, 31 - i);
            sample(0);
        end
        bus_b.rd_addr = 16'hFA50;
        sample(1);
        rst_n = 1'b1;
        tick();

        // Writes, including a discarded write to r0.
        drive_a(1, 1, 32'd15, 0, 0);         tick();
        drive_a(1, 3, 32'd20, 0, 0);         tick();
        drive_a(1, 0, 32'hDEADBEEF, 0, 0);   tick();
        drive_a(0, 0, 32'd0, 0, 0);
        set_rd_a(1, 3);
        sample(0);
        check_eq("r1_is_15", get_act(0, 0, 0), 64'd15);
        check_eq("r3_is_20", get_act(0, 0, 1), 64'd20);
        set_rd_a(0, 0);
        sample(0);
        check_eq("r0_is_0", get_act(0, 0, 0), 64'd0);

        // Same-cycle write/read: forwarded on unit 0, visible a cycle later on unit 1.
        drive_a(1, 5, 32'h1234, 0, 0);
        set_rd_a(5, 1);
        bus_b.wr_en = 1'b1; bus_b.wr_addr = 4'd5; bus_b.wr_data = 64'h1234; bus_b.rd_addr = 16'h0005;
        sample(0);
        sample(1);
        check_eq("bypass_on_r5", get_act(0, 0, 0), 64'h1234);
        check_eq("bypass_off_r5_old", get_act(1, 0, 0), 64'd0);
        tick();
        drive_a(0, 0, 32'd0, 0, 0);
        bus_b.wr_en = 1'b0;
        sample(0);
        sample(1);
        check_eq("bypass_off_r5_new", get_act(1, 0, 0), 64'h1234);

        // Issue tracking.
        drive_a(0, 0, 0, 1, 7);  tick();
        drive_a(0, 0, 0, 1, 9);  tick();
        drive_a(0, 0, 0, 0, 0);
        set_rd_a(7, 9);
        sample(0);
        check_eq("cnt_after_r7_r9", get_act(0, 2, 0), 64'd2);
        drive_a(1, 7, 32'd70, 0, 0); tick();
        drive_a(0, 0, 0, 0, 0);
        sample(0);
        check_eq("cnt_after_wr_r7", get_act(0, 2, 0), 64'd1);
        check_eq("r7_not_busy", get_act(0, 1, 0), 64'd0);
        drive_a(0, 0, 0, 1, 0);  tick();
        drive_a(0, 0, 0, 0, 0);
        sample(0);
        check_eq("cnt_after_iss_r0", get_act(0, 2, 0), 64'd1);

        // Simultaneous issue and writeback to r4, first busy then idle.
        drive_a(0, 0, 0, 1, 4);  tick();
        drive_a(1, 4, 32'd99, 1, 4);
        set_rd_a(4, 9);
        sample(0);
        check_eq("r4_bypass_not_busy", get_act(0, 1, 0), 64'd0);
        tick();
        drive_a(0, 0, 0, 0, 0);
        sample(0);
        check_eq("r4_reads_99", get_act(0, 0, 0), 64'd99);
        check_eq("r4_still_busy", get_act(0, 1, 0), 64'd1);
        check_eq("cnt_iss_wr_busy", get_act(0, 2, 0), 64'd2);
        drive_a(1, 4, 32'd50, 0, 0); tick();
        drive_a(0, 0, 0, 0, 0);
        sample(0);
        drive_a(1, 4, 32'd77, 1, 4); tick();
        drive_a(0, 0, 0, 0, 0);
        sample(0);
        check_eq("cnt_iss_wr_idle", get_act(0, 2, 0), 64'd2);
        check_eq("r4_reads_77", get_act(0, 0, 0), 64'd77);

        // Asynchronous reset mid-run: outputs clear without a clock edge.
        set_rd_a(1, 3);
        sample(0);
        rst_n = 1'b0;
        #1;
        check_eq("async_rst_rd0", get_act(0, 0, 0), 64'd0);
        check_eq("async_rst_rd1", get_act(0, 0, 1), 64'd0);
        check_eq("async_rst_cnt", get_act(0, 2, 0), 64'd0);
        check_eq("async_rst_any", get_act(0, 3, 0), 64'd0);
        sample(0);
        tick();
        rst_n = 1'b1;
        tick();

        // Random traffic on the 16x64, four-port, non-bypassing unit.
        for (int c = 0; c < 10000; c++) begin
            bus_b.wr_en    = ($urandom_range(0, 1) == 1);
            bus_b.wr_addr  = 4'($urandom);
            bus_b.wr_data  = {$urandom, $urandom};
            bus_b.iss_en   = ($urandom_range(0, 4) < 2);
            bus_b.iss_addr = 4'($urandom);
            bus_b.rd_addr  = 16'($urandom);
            sample(1);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
